insn_loader: RTL and testbench

INSN_LOADER -- requirements
Module: insn_loader

---
 rtl/insn_loader_pkg.sv | 45 ++++
 rtl/insn_loader_if.sv | 18 +
 rtl/insn_encoder.sv | 49 ++++
 rtl/insn_loader.sv | 103 ++++++++++
 tb/tb_insn_loader.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/insn_loader_pkg.sv
// Shared control constants for the instruction loader: format codes, RV32I opcodes,
// loader FSM encodings and the packed field bundle handed to the encoder.
package insn_loader_pkg;

    localparam logic [3:0] FMT_R       = 4'd0;
    localparam logic [3:0] FMT_I_ALU   = 4'd1;
    localparam logic [3:0] FMT_I_LOAD  = 4'd2;
    localparam logic [3:0] FMT_I_JALR  = 4'd3;
    localparam logic [3:0] FMT_S       = 4'd4;
    localparam logic [3:0] FMT_B       = 4'd5;
    localparam logic [3:0] FMT_U_LUI   = 4'd6;
    localparam logic [3:0] FMT_U_AUIPC = 4'd7;
    localparam logic [3:0] FMT_J       = 4'd8;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_I_LOAD = 7'b0000011;
    localparam logic [6:0] OP_I_JALR = 7'b1100111;
    localparam logic [6:0] OP_S      = 7'b0100011;
    localparam logic [6:0] OP_B      = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_J      = 7'b1101111;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ACCEPT = 3'd1;
    localparam logic [2:0] ST_SETUP  = 3'd2;
    localparam logic [2:0] ST_STROBE = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    typedef struct packed {
        logic [3:0]  fmt;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic        alt;
        logic [31:0] imm;
    } insn_fields_t;

    function automatic logic fmt_is_valid(input logic [3:0] f);
        return f <= FMT_J;
    endfunction

endpackage

// File: rtl/insn_loader_if.sv
// Instruction-field valid/ready channel into the loader; in_ready is returned by the loader.
interface insn_loader_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  fmt;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic        alt;
    logic [31:0] imm;
    logic        last;

    modport master (output in_valid, fmt, rd, rs1, rs2, funct3, alt, imm, last,
                    input  in_ready);
    modport slave  (input  in_valid, fmt, rd, rs1, rs2, funct3, alt, imm, last,
                    output in_ready);
endinterface

// File: rtl/insn_encoder.sv
// Combinational RV32I field-to-word encoder, zero latency, no flow control;
// word_ok is low for unknown format codes and the word is then zero.
module insn_encoder
    import insn_loader_pkg::*;
(
    input  insn_fields_t fields,
    output logic [31:0]  word,
    output logic         word_ok
);

    logic [6:0] shift_funct7;

    assign shift_funct7 = {1'b0, fields.alt, 5'b00000};

    always_comb begin
        word    = '0;
        word_ok = fmt_is_valid(fields.fmt);
        case (fields.fmt)
            FMT_R:
                word = {shift_funct7, fields.rs2, fields.rs1, fields.funct3, fields.rd, OP_R};
            FMT_I_ALU: begin
                // shift-immediates carry shamt plus the SRAI select bit instead of imm[11:5]
                if (fields.funct3 == 3'b001 || fields.funct3 == 3'b101)
                    word = {shift_funct7, fields.imm[4:0], fields.rs1, fields.funct3, fields.rd, OP_I_ALU};
                else
                    word = {fields.imm[11:0], fields.rs1, fields.funct3, fields.rd, OP_I_ALU};
            end
            FMT_I_LOAD:
                word = {fields.imm[11:0], fields.rs1, fields.funct3, fields.rd, OP_I_LOAD};
            FMT_I_JALR:
                word = {fields.imm[11:0], fields.rs1, 3'b000, fields.rd, OP_I_JALR};
            FMT_S:
                word = {fields.imm[11:5], fields.rs2, fields.rs1, fields.funct3, fields.imm[4:0], OP_S};
            FMT_B:
                word = {fields.imm[12], fields.imm[10:5], fields.rs2, fields.rs1, fields.funct3,
                        fields.imm[4:1], fields.imm[11], OP_B};
            FMT_U_LUI:
                word = {fields.imm[31:12], fields.rd, OP_LUI};
            FMT_U_AUIPC:
                word = {fields.imm[31:12], fields.rd, OP_AUIPC};
            FMT_J:
                word = {fields.imm[20], fields.imm[10:1], fields.imm[11], fields.imm[19:12],
                        fields.rd, OP_J};
            default:
                word = '0;
        endcase
    end

endmodule

// File: rtl/insn_loader.sv
// Loads encoded instructions into a strobed memory port: ACCEPT -> SETUP -> STROBE, 3 cycles/word;
// in_ready is high only in ACCEPT, so the source is stalled while a write is in flight.
module insn_loader
    import insn_loader_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [31:0]  base_addr,
    insn_loader_if.slave fld,
    output logic [31:0]  mem_addr,
    output logic [31:0]  mem_data,
    output logic         mem_clk,
    output logic         busy,
    output logic         done,
    output logic         error,
    output logic [15:0]  count
);

    logic [2:0]   state;
    logic [31:0]  next_addr;
    logic         last_q;
    insn_fields_t fields;
    logic [31:0]  enc_word;
    logic         enc_ok;
    logic         hs;

    assign fields = '{fmt:    fld.fmt,
                      rd:     fld.rd,
                      rs1:    fld.rs1,
                      rs2:    fld.rs2,
                      funct3: fld.funct3,
                      alt:    fld.alt,
                      imm:    fld.imm};

    insn_encoder u_enc (
        .fields  (fields),
        .word    (enc_word),
        .word_ok (enc_ok)
    );

    assign fld.in_ready = (state == ST_ACCEPT);
    assign hs           = fld.in_valid && fld.in_ready;
    assign busy         = (state != ST_IDLE);
    assign done         = (state == ST_DONE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            next_addr <= '0;
            last_q    <= 1'b0;
            mem_addr  <= '0;
            mem_data  <= '0;
            mem_clk   <= 1'b0;
            error     <= 1'b0;
            count     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_ACCEPT;
                        next_addr <= base_addr;
                        count     <= '0;
                        error     <= 1'b0;
                    end
                end
                ST_ACCEPT: begin
                    if (hs) begin
                        if (enc_ok) begin
                            mem_data <= enc_word;
                            mem_addr <= next_addr;
                            last_q   <= fld.last;
                            state    <= ST_SETUP;
                        end else begin
                            // bad format: drop the word, keep address/count, flag it
                            error <= 1'b1;
                            if (fld.last)
                                state <= ST_DONE;
                        end
                    end
                end
                ST_SETUP: begin
                    mem_clk <= 1'b1;
                    state   <= ST_STROBE;
                end
                ST_STROBE: begin
                    mem_clk   <= 1'b0;
                    next_addr <= next_addr + 32'd4;
                    if (count != 16'hFFFF)
                        count <= count + 16'd1;
                    state <= last_q ? ST_DONE : ST_ACCEPT;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_insn_loader.sv
// Randomized and directed bench for insn_loader with an arithmetic RV32I reference model
// and a write scoreboard fed by the driver and drained by a strobe monitor.
module tb_insn_loader;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [31:0] base_addr;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_clk;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] count;

    insn_loader_if fld ();

    insn_loader dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .base_addr (base_addr),
        .fld       (fld),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_clk   (mem_clk),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .count     (count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] exp_a[$];
    logic [31:0] exp_d[$];
    logic [31:0] model_addr;
    int          model_cnt;
    logic        model_err;
    logic [31:0] last_w_addr = '0;
    logic [31:0] last_w_data = '0;
    logic        prev_mc = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [3:0] f, input logic [4:0] rd,
                                             input logic [4:0] rs1, input logic [4:0] rs2,
                                             input logic [2:0] f3, input logic a,
                                             input logic [31:0] imm);
        logic [31:0] rdf, r1, r2, f3f, af;
        rdf = 32'(rd) << 7;
        r1  = 32'(rs1) << 15;
        r2  = 32'(rs2) << 20;
        f3f = 32'(f3) << 12;
        af  = 32'(a) << 30;
        case (f)
            4'd0: return af | r2 | r1 | f3f | rdf | 32'h33;
            4'd1: begin
                if (f3 == 3'd1 || f3 == 3'd5)
                    return af | ((imm & 32'd31) << 20) | r1 | f3f | rdf | 32'h13;
                return ((imm & 32'hFFF) << 20) | r1 | f3f | rdf | 32'h13;
            end
            4'd2: return ((imm & 32'hFFF) << 20) | r1 | f3f | rdf | 32'h03;
            4'd3: return ((imm & 32'hFFF) << 20) | r1 | rdf | 32'h67;
            4'd4: return (((imm >> 5) & 32'd127) << 25) | r2 | r1 | f3f | ((imm & 32'd31) << 7) | 32'h23;
            4'd5: return (((imm >> 12) & 32'd1) << 31) | (((imm >> 5) & 32'd63) << 25) | r2 | r1 | f3f
                         | (((imm >> 1) & 32'd15) << 8) | (((imm >> 11) & 32'd1) << 7) | 32'h63;
            4'd6: return (imm & 32'hFFFFF000) | rdf | 32'h37;
            4'd7: return (imm & 32'hFFFFF000) | rdf | 32'h17;
            4'd8: return (((imm >> 20) & 32'd1) << 31) | (((imm >> 1) & 32'd1023) << 21)
                         | (((imm >> 11) & 32'd1) << 20) | (imm & 32'h000FF000) | rdf | 32'h6F;
            default: return 32'h0;
        endcase
    endfunction

    // strobe monitor: every mem_clk pulse must match the oldest expected write
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (mem_clk === 1'b1) begin
                chk("strobe_single", 32'(prev_mc), 32'd0);
                if (exp_a.size() == 0) begin
                    chk("unexpected_strobe", 32'd1, 32'd0);
                end else begin
                    last_w_addr = exp_a.pop_front();
                    last_w_data = exp_d.pop_front();
                    chk("wr_addr", mem_addr, last_w_addr);
                    chk("wr_data", mem_data, last_w_data);
                end
            end
            prev_mc = mem_clk;
        end else begin
            prev_mc = 1'b0;
        end
    end

    task automatic open_session(input logic [31:0] b);
        @(posedge clk); #1;
        start     = 1'b1;
        base_addr = b;
        @(posedge clk); #1;
        start      = 1'b0;
        base_addr  = $urandom;
        model_addr = b;
        model_cnt  = 0;
        model_err  = 1'b0;
    endtask

    task automatic send_word(input logic [3:0] f, input logic [4:0] rd, input logic [4:0] rs1,
                             input logic [4:0] rs2, input logic [2:0] f3, input logic a,
                             input logic [31:0] im, input logic lst, input int gap);
        bit hs = 1'b0;
        if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
        end
        fld.fmt = f; fld.rd = rd; fld.rs1 = rs1; fld.rs2 = rs2;
        fld.funct3 = f3; fld.alt = a; fld.imm = im; fld.last = lst;
        fld.in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (fld.in_ready === 1'b1) begin
                hs = 1'b1;
                break;
            end
        end
        chk("handshake", 32'(hs), 32'd1);
        if (hs) begin
            if (f <= 4'd8) begin
                exp_a.push_back(model_addr);
                exp_d.push_back(ref_word(f, rd, rs1, rs2, f3, a, im));
                model_addr = model_addr + 32'd4;
                model_cnt++;
            end else begin
                model_err = 1'b1;
            end
        end
        @(posedge clk); #1;
        fld.in_valid = 1'b0;
        fld.fmt      = 4'($urandom);
        fld.imm      = $urandom;
    endtask

    task automatic close_session();
        bit seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done_seen", 32'(seen), 32'd1);
        chk("count", 32'(count), 32'(model_cnt));
        chk("error", 32'(error), 32'(model_err));
        chk("queue_drained", 32'(exp_a.size()), 32'd0);
        chk("hold_addr", mem_addr, last_w_addr);
        chk("hold_data", mem_data, last_w_data);
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
    endtask

    task automatic check_reset_outputs();
        chk("rst_mem_clk", 32'(mem_clk), 32'd0);
        chk("rst_in_ready", 32'(fld.in_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_data", mem_data, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0; start = 1'b0; base_addr = '0;
        fld.in_valid = 1'b0; fld.fmt = '0; fld.rd = '0; fld.rs1 = '0; fld.rs2 = '0;
        fld.funct3 = '0; fld.alt = 1'b0; fld.imm = '0; fld.last = 1'b0;
        #3;
        check_reset_outputs();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_idle", 32'(busy), 32'd0);

        // single ADDI x1, x0, 5
        open_session(32'h100);
        send_word(4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5, 1'b1, 0);
        close_session();
        chk("v28_data", mem_data, 32'h00500093);
        chk("v28_addr", mem_addr, 32'h100);

        // SUB then BEQ -4
        open_session(32'h0);
        send_word(4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 32'd0, 1'b0, 0);
        send_word(4'd5, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, -32'sd4, 1'b1, 0);
        close_session();
        chk("v29_data", mem_data, 32'hFE208EE3);
        chk("v29_addr", mem_addr, 32'h4);

        // JAL then LUI with idle gaps on the source side
        open_session(32'h200);
        send_word(4'd8, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd8, 1'b0, 5);
        send_word(4'd6, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 32'h12345000, 1'b1, 5);
        close_session();
        chk("v30_data", mem_data, 32'h123452B7);

        // address wrap
        open_session(32'hFFFFFFFC);
        send_word(4'd2, 5'd4, 5'd2, 5'd0, 3'd2, 1'b0, 32'h10, 1'b0, 0);
        send_word(4'd4, 5'd0, 5'd2, 5'd4, 3'd2, 1'b0, 32'h14, 1'b1, 1);
        close_session();
        chk("v31_addr", mem_addr, 32'h0);

        // invalid format mid-session
        open_session(32'h300);
        send_word(4'd1, 5'd2, 5'd2, 5'd0, 3'd5, 1'b1, 32'h403, 1'b0, 0);
        send_word(4'd12, 5'd1, 5'd1, 5'd1, 3'd0, 1'b0, 32'h0, 1'b0, 0);
        send_word(4'd3, 5'd1, 5'd6, 5'd0, 3'd7, 1'b0, 32'hFFF, 1'b1, 2);
        close_session();
        chk("v32_addr", mem_addr, 32'h304);
        chk("v32_error", 32'(error), 32'd1);

        // start while busy is ignored, then reset lands in the strobe cycle
        open_session(32'h400);
        @(posedge clk); #1;
        start = 1'b1; base_addr = 32'h5000;
        @(posedge clk); #1;
        start = 1'b0;
        send_word(4'd7, 5'd9, 5'd0, 5'd0, 3'd0, 1'b0, 32'hABCDE123, 1'b0, 0);
        @(posedge clk); #2;
        chk("pre_rst_strobe", 32'(mem_clk), 32'd1);
        chk("pre_rst_addr", mem_addr, 32'h400);
        reset_n = 1'b0;
        start   = 1'b1;
        #1;
        check_reset_outputs();
        exp_a.delete();
        exp_d.delete();
        last_w_addr = '0;
        last_w_data = '0;
        @(posedge clk); #1;
        start = 1'b0;
        reset_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_data", mem_data, 32'd0);

        // randomized sessions
        for (int s = 0; s < 16; s++) begin
            int nw;
            logic [31:0] b;
            nw = $urandom_range(1, 5);
            b  = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF8 : ($urandom & 32'hFFFFFFFC);
            open_session(b);
            for (int w = 0; w < nw; w++) begin
                logic [3:0] f;
                f = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
                send_word(f, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom),
                          1'($urandom), $urandom, (w == nw - 1), $urandom_range(0, 3));
            end
            close_session();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
